// File: rtl/input_control.sv
// -----------------------------------------------------------------------------
// input_control
//   Fetches one dense operand tile (LANE_COUNT lanes x N rows) from L2 BRAM
//   into a local L1 buffer, then streams it into the PE array with a
//   one-cycle-per-group diagonal skew: group p receives row r in stream
//   cycle r+p. stream_done pulses once the last skewed beat has left.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   input_start       start request, sampled only in IDLE
//   input_address     L2 read byte address (lane-major layout)
//   input_L2_enable   L2 read enable
//   input_L2_wenable  L2 byte write enable, tied to 0 (read-only client)
//   input_data        L2 read data, valid one cycle after the enable cycle
//   stream_data[p]    skewed operand for PE group p, slot a at [a*DW +: DW]
//   stream_valid[p]   per-group beat valid
//   stream_done       one-cycle pulse at end of stream
//   busy              high in every state except IDLE and RESET
// -----------------------------------------------------------------------------
module input_control #(
  parameter int          M            = 4,
  parameter int          ALPHA        = 2,
  parameter int          DATA_WIDTH   = 16,
  parameter int          N            = 4,
  parameter logic [31:0] BASE_ADDRESS = 32'h4000_0000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          input_start,
  output logic [31:0]                   input_address,
  output logic                          input_L2_enable,
  output logic [3:0]                    input_L2_wenable,
  input  logic [31:0]                   input_data,
  output logic [ALPHA*DATA_WIDTH-1:0]   stream_data  [0:M/ALPHA-1],
  output logic                          stream_valid [0:M/ALPHA-1],
  output logic                          stream_done,
  output logic                          busy
);

  localparam int M_SCALED   = M / ALPHA;
  localparam int LANE_COUNT = M_SCALED * ALPHA;
  localparam int TOTAL      = LANE_COUNT * N;     // reads per tile
  localparam int STREAM_LEN = N + M_SCALED - 1;   // skewed stream cycles
  localparam int BYTES      = DATA_WIDTH / 8;
  localparam int I_W        = $clog2(TOTAL + 1);
  localparam int C_W        = $clog2(STREAM_LEN + 1);
  localparam int AW         = (TOTAL > 1) ? $clog2(TOTAL) : 1;

  typedef enum logic [2:0] {
    S_RESET, S_IDLE, S_FETCH, S_FETCH_DRAIN, S_STREAM, S_DONE
  } state_t;

  state_t                       state_q, state_d;
  logic [I_W-1:0]               cnt_i_q, cnt_i_d, cnt_i_nxt;
  logic [C_W-1:0]               cnt_c_q, cnt_c_d;
  logic [31:0]                  addr_d;
  logic                         en_d, done_d, busy_d;
  logic [ALPHA*DATA_WIDTH-1:0]  data_d  [0:M_SCALED-1];
  logic                         valid_d [0:M_SCALED-1];

  // Capture pipeline: the read issued in cycle k returns in cycle k+1, so
  // the issued L1 index is delayed by one cycle alongside a pending flag.
  logic                         rd_pend_q;
  logic [AW-1:0]                cap_idx_q;

  // L1 is flat and lane-major: entry (lane, row) lives at lane*N + row,
  // which is also the issue counter value of the read that fills it.
  logic [DATA_WIDTH-1:0]        l1_mem [0:TOTAL-1];

  // Only the low DATA_WIDTH bits of the L2 word carry an element.
  logic unused_data;
  assign unused_data = ^input_data;

  assign input_L2_wenable = 4'b0000;
  assign cnt_i_nxt        = cnt_i_q + I_W'(1);

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_i_d = cnt_i_q;
    cnt_c_d = cnt_c_q;
    addr_d  = input_address;
    en_d    = 1'b0;
    done_d  = 1'b0;
    valid_d = '{default: 1'b0};
    data_d  = '{default: '0};

    case (state_q)
      S_RESET: state_d = S_IDLE;

      S_IDLE: begin
        if (input_start) begin
          state_d = S_FETCH;
          cnt_i_d = '0;
          en_d    = 1'b1;
          addr_d  = BASE_ADDRESS;
        end
      end

      S_FETCH: begin
        if (cnt_i_q == I_W'(TOTAL - 1)) begin
          state_d = S_FETCH_DRAIN;
        end else begin
          cnt_i_d = cnt_i_nxt;
          en_d    = 1'b1;
          // (lane*N + row) == issue index, so the lane-major address is linear.
          addr_d  = BASE_ADDRESS + 32'(cnt_i_nxt) * 32'(BYTES);
        end
      end

      S_FETCH_DRAIN: begin
        cnt_c_d = '0;
        state_d = S_STREAM;
      end

      S_STREAM: begin
        for (int p = 0; p < M_SCALED; p++) begin
          if (int'(cnt_c_q) >= p && int'(cnt_c_q) < p + N) begin
            valid_d[p] = 1'b1;
            for (int a = 0; a < ALPHA; a++) begin
              data_d[p][a*DATA_WIDTH +: DATA_WIDTH] =
                l1_mem[AW'((ALPHA*p + a)*N + int'(cnt_c_q) - p)];
            end
          end
        end
        if (cnt_c_q == C_W'(STREAM_LEN - 1)) state_d = S_DONE;
        else                                 cnt_c_d = cnt_c_q + C_W'(1);
      end

      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_RESET;
    endcase
  end

  assign busy_d = (state_d != S_IDLE) && (state_d != S_RESET);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_RESET;
      cnt_i_q         <= '0;
      cnt_c_q         <= '0;
      input_address   <= '0;
      input_L2_enable <= 1'b0;
      stream_data     <= '{default: '0};
      stream_valid    <= '{default: 1'b0};
      stream_done     <= 1'b0;
      busy            <= 1'b0;
      rd_pend_q       <= 1'b0;
      cap_idx_q       <= '0;
    end else begin
      state_q         <= state_d;
      cnt_i_q         <= cnt_i_d;
      cnt_c_q         <= cnt_c_d;
      input_address   <= addr_d;
      input_L2_enable <= en_d;
      stream_data     <= data_d;
      stream_valid    <= valid_d;
      stream_done     <= done_d;
      busy            <= busy_d;
      rd_pend_q       <= (state_q == S_FETCH);
      cap_idx_q       <= AW'(cnt_i_q);
    end
  end

  // NOTE: the L1 array has no reset; every entry is rewritten by a fetch
  // before streaming reads it, so clearing it would only cost logic.
  always_ff @(posedge clk) begin
    if (rd_pend_q) l1_mem[cap_idx_q] <= input_data[DATA_WIDTH-1:0];
  end

endmodule

// File: tb/tb_input_control.sv
// -----------------------------------------------------------------------------
// tb_input_control
//   Directed bench for input_control. A default-parameter instance is run
//   through a plain tile, ignored start pulses, a mid-fetch reset and
//   back-to-back tiles; a second instance (M=2, ALPHA=2, N=1) covers the
//   degenerate single-row, single-group case. L2 models return
//   {16'hABCD, 0x0100*lane + row} one cycle after each enabled read.
// -----------------------------------------------------------------------------
module tb_input_control;

  localparam logic [31:0] BASE  = 32'h4000_0000;
  localparam int          TOTAL = 16;  // 4 lanes x 4 rows
  localparam int          SLEN  = 5;   // N + M_SCALED - 1

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  // default instance
  logic        start = 1'b0;
  logic [31:0] addr, din;
  logic        en, done, busy;
  logic [3:0]  wen;
  logic [31:0] sd [0:1];
  logic        sv [0:1];

  // small instance
  logic        start_s = 1'b0;
  logic [31:0] addr_s, din_s;
  logic        en_s, done_s, busy_s;
  logic [3:0]  wen_s;
  logic [31:0] sd_s [0:0];
  logic        sv_s [0:0];

  input_control dut (
    .clk(clk), .rst_n(rst_n), .input_start(start),
    .input_address(addr), .input_L2_enable(en), .input_L2_wenable(wen),
    .input_data(din), .stream_data(sd), .stream_valid(sv),
    .stream_done(done), .busy(busy)
  );

  input_control #(.M(2), .ALPHA(2), .N(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .input_start(start_s),
    .input_address(addr_s), .input_L2_enable(en_s), .input_L2_wenable(wen_s),
    .input_data(din_s), .stream_data(sd_s), .stream_valid(sv_s),
    .stream_done(done_s), .busy(busy_s)
  );

  function automatic logic [15:0] elem(int lane, int row);
    return 16'(256*lane + row);
  endfunction

  function automatic logic [31:0] l2_word(logic [31:0] a, int rows);
    int idx;
    idx = int'((a - BASE) >> 1);
    return {16'hABCD, elem(idx / rows, idx % rows)};
  endfunction

  // L2 models: one-cycle read latency, junk when not enabled.
  always @(posedge clk) begin
    din   <= en   ? l2_word(addr, 4)   : 32'hDEAD_BEEF;
    din_s <= en_s ? l2_word(addr_s, 1) : 32'hDEAD_BEEF;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected outputs of the default instance t cycles after the start edge:
  // reads in cycles 0..15, drain 16, stream 17..21, DONE 22, pulse in 23.
  // Beat b is visible in cycle 18+b.
  task automatic check_cycle(input string tag, input int t);
    string s;
    int    b;
    logic  exp_v;
    logic [31:0] exp_d;
    s = $sformatf("%s t%0d", tag, t);
    b = t - (TOTAL + 2);
    check({s, " en"}, en, t < TOTAL);
    if (t < TOTAL) check({s, " addr"}, addr, BASE + 32'(2*t));
    check({s, " wen"},  wen,  4'b0000);
    check({s, " busy"}, busy, t <= TOTAL + SLEN + 1);
    check({s, " done"}, done, t == TOTAL + SLEN + 2);
    for (int p = 0; p < 2; p++) begin
      exp_v = (b >= p) && (b < p + 4);
      exp_d = exp_v ? {elem(2*p + 1, b - p), elem(2*p, b - p)} : 32'h0;
      check($sformatf("%s valid%0d", s, p), sv[p], exp_v);
      check($sformatf("%s data%0d", s, p),  sd[p], exp_d);
    end
  endtask

  // Called at a negedge with the DUT in IDLE. pulse_a/pulse_b raise start
  // for one cycle mid-run; keep holds start high for a back-to-back tile.
  task automatic run_tile(input string tag, input int pulse_a, input int pulse_b, input bit keep);
    int last;
    last  = keep ? TOTAL + SLEN + 2 : TOTAL + SLEN + 3;
    start = 1'b1;
    for (int t = 0; t <= last; t++) begin
      @(negedge clk);
      check_cycle(tag, t);
      start = keep || (t == pulse_a) || (t == pulse_b);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // small-instance vectors, cycles 0..6 after the start edge
  localparam logic [6:0] S_EN    = 7'b0000011;
  localparam logic [6:0] S_VALID = 7'b0010000;
  localparam logic [6:0] S_DONE  = 7'b0100000;
  localparam logic [6:0] S_BUSY  = 7'b0011111;

  initial begin
    logic [6:0] tbl_en, tbl_v, tbl_d, tbl_b;
    tbl_en = S_EN; tbl_v = S_VALID; tbl_d = S_DONE; tbl_b = S_BUSY;

    // reset state
    repeat (2) @(negedge clk);
    check("reset en",    en,    1'b0);
    check("reset addr",  addr,  32'h0);
    check("reset wen",   wen,   4'h0);
    check("reset busy",  busy,  1'b0);
    check("reset done",  done,  1'b0);
    check("reset v0",    sv[0], 1'b0);
    check("reset v1",    sv[1], 1'b0);
    check("reset d0",    sd[0], 32'h0);
    check("reset d1",    sd[1], 32'h0);
    check("reset en_s",  en_s,  1'b0);
    check("reset busy_s", busy_s, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle busy", busy, 1'b0);
    check("idle en",   en,   1'b0);

    run_tile("tile", -1, -1, 1'b0);
    run_tile("ignore", 5, 19, 1'b0);

    // abort mid-fetch at read 7
    start = 1'b1;
    for (int t = 0; t <= 7; t++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("abort read7 en",   en,   1'b1);
    check("abort read7 addr", addr, BASE + 32'd14);
    rst_n = 1'b0;
    #1;
    check("abort en",   en,    1'b0);
    check("abort done", done,  1'b0);
    check("abort busy", busy,  1'b0);
    check("abort v0",   sv[0], 1'b0);
    check("abort v1",   sv[1], 1'b0);
    check("abort addr", addr,  32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_tile("refetch", -1, -1, 1'b0);

    // start held high: second tile's first read right after the done cycle
    run_tile("b2b1", -1, -1, 1'b1);
    run_tile("b2b2", -1, -1, 1'b0);

    // M=2, ALPHA=2, N=1
    start_s = 1'b1;
    for (int t = 0; t <= 6; t++) begin
      @(negedge clk);
      start_s = 1'b0;
      check($sformatf("small t%0d en", t),   en_s,   tbl_en[t]);
      if (tbl_en[t]) check($sformatf("small t%0d addr", t), addr_s, BASE + 32'(2*t));
      check($sformatf("small t%0d wen", t),  wen_s,  4'h0);
      check($sformatf("small t%0d valid", t), sv_s[0], tbl_v[t]);
      check($sformatf("small t%0d data", t),  sd_s[0], tbl_v[t] ? 32'h0100_0000 : 32'h0);
      check($sformatf("small t%0d done", t), done_s, tbl_d[t]);
      check($sformatf("small t%0d busy", t), busy_s, tbl_b[t]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/input_control.md
Name: input_control

Overview:
- Upstream counterpart of the output controller in the VEGETA accelerator.
- On `input_start`, fetches one dense operand tile (LANE_COUNT lanes × N rows) from L2 BRAM into a local L1 buffer.
- Streams the tile into the PE array with a one-cycle-per-PE diagonal skew, so column group `p` receives row `r` at stream cycle `r+p`.
- Pulses `stream_done` when the last skewed beat has left.

Parameters:
- M, 4, PE array width in lanes.
- ALPHA, 2, lanes per PE group; M_SCALED = M/ALPHA (localparam); LANE_COUNT = M_SCALED*ALPHA (localparam).
- DATA_WIDTH, 16, element width; must be ≤32 and a multiple of 8.
- N, 4, rows per lane (L1 depth).
- BASE_ADDRESS, 32'h4000_0000, L2 byte address of element (lane 0, row 0).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- input_start  in  1  start request; sampled only in IDLE.
- input_address  out  32  L2 read byte address.
- input_L2_enable  out  1  L2 read enable.
- input_L2_wenable  out  4  L2 byte write enable; always 4'b0000.
- input_data  in  32  L2 read data; valid exactly 1 cycle after the enable cycle; bits [DATA_WIDTH-1:0] used.
- stream_data  out  ALPHA*DATA_WIDTH × M_SCALED (unpacked [0:M_SCALED-1])  skewed operand to PE group p; slot a at bits [a*DATA_WIDTH +: DATA_WIDTH].
- stream_valid  out  1 × M_SCALED (unpacked [0:M_SCALED-1])  per-group beat valid.
- stream_done  out  1  one-cycle pulse at end of stream.
- busy  out  1  high in every state except IDLE and RESET.

Behaviour:
- Reset (async, `rst_n`=0):
  - state=RESET; all outputs 0; `input_address`=0; all counters 0.
  - L1 contents are not cleared and are don't-care.
  - RESET→IDLE unconditionally on the next clock.
- All outputs are registered. Only the "next" values are combinational.
- States: RESET, IDLE, FETCH, FETCH_DRAIN, STREAM, DONE.
- IDLE:
  - If `input_start`=1: go to FETCH; issue-counter i←0; register `input_L2_enable`=1 and `input_address`=BASE_ADDRESS.
  - Otherwise stay, with `input_L2_enable`=0.
- FETCH (issue phase): one read is issued per cycle, i = 0 … LANE_COUNT*N−1.
  - lane = i / N; row = i % N.
  - address = BASE_ADDRESS + (lane*N + row)*(DATA_WIDTH/8). This matches the output controller's lane-major layout.
  - The cycle after read i is issued, `input_data[DATA_WIDTH-1:0]` is written to L1[lane][row]. A registered copy of the issued (lane,row) tracks this.
  - After issuing i = LANE_COUNT*N−1, go to FETCH_DRAIN with `input_L2_enable`=0.
- FETCH_DRAIN (1 cycle): capture the final word, clear stream counter c←0, go to STREAM.
- STREAM: runs for N+M_SCALED−1 cycles, c = 0 … N+M_SCALED−2. For each group p, the output registers loaded in cycle c are:
  - If p ≤ c < p+N: `stream_valid`[p]=1; slot a of `stream_data`[p] = L1[ALPHA*p+a][c−p].
  - Otherwise: valid=0 and data=0.
  - Beat c is therefore visible on the outputs in cycle c+1 of STREAM (1-cycle latency).
  - After c = N+M_SCALED−2, go to DONE.
- DONE (1 cycle):
  - All `stream_valid`=0 and all `stream_data`=0.
  - `stream_done` register loaded to 1, so the pulse is visible the cycle after DONE (coincident with IDLE).
  - Go to IDLE.
- Handshake and boundary rules:
  - `input_start` is ignored in all states except IDLE; a pulse during busy is dropped, not queued.
  - `input_start` held high through DONE starts a new tile the cycle after returning to IDLE; back-to-back tiles are allowed.
  - Width rules:
    - The address multiply is 32-bit unsigned with no overflow check.
    - Counter widths use the team's clog2 macro, plus 1 bit where the terminal count equals the depth.
  - N=1: FETCH issues LANE_COUNT reads; STREAM lasts M_SCALED cycles.
  - M_SCALED=1: STREAM has no skew; all lanes are valid for exactly N cycles.
  - Reset asserted mid-FETCH or mid-STREAM aborts immediately. Outputs go to reset values; the next `input_start` refetches the whole tile.

Test Plan:
- Defaults, L2 model with 1-cycle latency, mem[(addr−BASE)/2] = 0x0100*lane + row; pulse `input_start` -> 16 reads at 0x4000_0000, 0x4000_0002 … 0x4000_001E on consecutive cycles, `input_L2_wenable` always 0, `busy`=1 from the cycle after start.
- Same run, stream phase -> 5 beats; group0 valid on beats 0–3 with data {0x0100+r, 0x0000+r} (slot1, slot0) for row r; group1 valid on beats 1–4 with {0x0300+r, 0x0200+r}; beat 0 group1 valid=0, data=0; `stream_done` single pulse after beat 4, then `busy`=0.
- `input_start` pulsed during FETCH and during STREAM -> no effect; reads and beats identical to the first test.
- `rst_n` low for 1 cycle at read 7 -> `input_L2_enable`, `stream_valid`, `stream_done` all 0; after new start, 16 reads restart at 0x4000_0000 and the stream matches the first two tests.
- `input_start` held high continuously -> two full tiles with exactly RESET-free IDLE gap of one cycle between `stream_done` and the second read at 0x4000_0000.
- M=2, ALPHA=2, N=1 -> 2 reads (0x4000_0000, 0x4000_0002), 1 beat with group0 valid, `stream_done` pulse.
